// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset main controller: Moore FSM with memory-ready and
// zero-flag qualification, plus a retired-instruction counter.
module mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             ExtZero,
  output logic             illegal_op,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [2:0]       ALUOp,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Opcode / funct decode of the held instruction register fields
  logic op_lw, op_sw, op_rtype, op_beq, op_bne, op_j, op_imm, funct_ok, ext_zero;
  logic [2:0] r_aluop, i_aluop;

  assign op_lw    = (opcode == 6'h23);
  assign op_sw    = (opcode == 6'h2B);
  assign op_rtype = (opcode == 6'h00);
  assign op_beq   = (opcode == 6'h04);
  assign op_bne   = (opcode == 6'h05);
  assign op_j     = (opcode == 6'h02);
  assign op_imm   = (opcode == 6'h08) || (opcode == 6'h0C) ||
                    (opcode == 6'h0D) || (opcode == 6'h0A);
  assign ext_zero = (opcode == 6'h0C) || (opcode == 6'h0D);

  // R-type ALU operation and funct legality
  always_comb begin
    r_aluop  = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      6'h20:   r_aluop = ALU_ADD;
      6'h22:   r_aluop = ALU_SUB;
      6'h24:   r_aluop = ALU_AND;
      6'h25:   r_aluop = ALU_OR;
      6'h2A:   r_aluop = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  // I-type ALU operation
  always_comb begin
    i_aluop = ALU_ADD;
    case (opcode)
      6'h0C:   i_aluop = ALU_AND;
      6'h0D:   i_aluop = ALU_OR;
      6'h0A:   i_aluop = ALU_SLT;
      default: i_aluop = ALU_ADD;
    endcase
  end

  // State and retired-counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and retirement logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op_lw || op_sw)             state_d = S_MEMADR;
        else if (op_rtype && funct_ok)  state_d = S_RTEXEC;
        else if (op_beq || op_bne)      state_d = S_BRANCH;
        else if (op_j)                  state_d = S_JUMP;
        else if (op_imm)                state_d = S_IEXEC;
        else                            state_d = S_FETCH;
      end
      S_MEMADR: begin
        if (op_lw)      state_d = S_MEMRD;
        else if (op_sw) state_d = S_MEMWR;
        else            state_d = S_FETCH;
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTEXEC: state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase

    // DECODE only falls back to FETCH on an illegal instruction; the MEMADR
    // fallback and unreachable encodings do not count as retirement.
    retired_d = retired_q;
    if ((state_d == S_FETCH) &&
        (state_q inside {S_DECODE, S_MEMWB, S_MEMWR, S_RTWB, S_BRANCH, S_JUMP, S_IWB}))
      retired_d = retired_q + CNT_W'(1);
  end

  // Moore outputs from the state register, with 1-bit outputs gated by reset
  always_comb begin
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ExtZero    = 1'b0;
    illegal_op = 1'b0;
    ALUSrcB    = 2'b00;
    PCSource   = 2'b00;
    ALUOp      = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !(op_lw || op_sw || (op_rtype && funct_ok) ||
                       op_beq || op_bne || op_j || op_imm);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        RegDst   = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_RTEXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = r_aluop;
      end
      S_RTWB: begin
        RegWrite = 1'b1;
        ALUOp    = r_aluop;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = 2'b01;
        PCWrite  = (op_beq && zero) || (op_bne && !zero);
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = i_aluop;
        ExtZero = ext_zero;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        ALUOp    = i_aluop;
        ExtZero  = ext_zero;
      end
      default: begin
      end
    endcase

    if (!rst) begin
      PCWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ExtZero    = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: randomized instruction streams checked
// against a path/latency model of the multicycle controller.
module tb_mc_ctrl;

  logic        clk, rst, zero, mem_ready;
  logic [5:0]  opcode, funct;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg;
  logic        RegWrite, ALUSrcA, ExtZero, illegal_op;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic [3:0]  state;
  logic [31:0] retired;
  logic [17:0] act;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_retired = 0;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ExtZero(ExtZero),
    .illegal_op(illegal_op), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .state(state), .retired(retired)
  );

  assign act = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                RegWrite, ALUSrcA, ExtZero, illegal_op, ALUSrcB, PCSource, ALUOp};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Instruction class: 0 lw, 1 sw, 2 R-type, 3 I-type, 4 branch, 5 jump, 6 illegal
  function automatic int klass(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23: return 0;
      6'h2B: return 1;
      6'h00: return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                     fn == 6'h25 || fn == 6'h2A) ? 2 : 6;
      6'h08, 6'h0C, 6'h0D, 6'h0A: return 3;
      6'h04, 6'h05: return 4;
      6'h02: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic logic [2:0] r_op(input logic [5:0] fn);
    case (fn)
      6'h22: return 3'd1;
      6'h24: return 3'd2;
      6'h25: return 3'd3;
      6'h2A: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] i_op(input logic [5:0] op);
    case (op)
      6'h0C: return 3'd2;
      6'h0D: return 3'd3;
      6'h0A: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Expected control word for one cycle of a given state number
  function automatic logic [17:0] exp_ctl(input int st, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z,
                                          input logic mr);
    logic pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, ez, ill;
    logic [1:0] bsrc, pcs;
    logic [2:0] aop;
    {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, ez, ill} = '0;
    bsrc = 2'b00; pcs = 2'b00; aop = 3'd0;
    case (st)
      0:  begin mrd = 1; bsrc = 2'b01; irw = mr; pcw = mr; end
      1:  begin bsrc = 2'b11; ill = (klass(op, fn) == 6); end
      2:  begin asa = 1; bsrc = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; rdst = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = r_op(fn); end
      7:  begin rw = 1; aop = r_op(fn); end
      8:  begin asa = 1; aop = 3'd1; pcs = 2'b01; pcw = (op == 6'h04) ? z : !z; end
      9:  begin pcs = 2'b10; pcw = 1; end
      10: begin asa = 1; bsrc = 2'b10; aop = i_op(op); ez = (op == 6'h0C || op == 6'h0D); end
      11: begin rw = 1; rdst = 1; aop = i_op(op); ez = (op == 6'h0C || op == 6'h0D); end
      default: ;
    endcase
    return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, ez, ill, bsrc, pcs, aop};
  endfunction

  // Run one instruction: build expected state path from the class and the
  // number of not-ready cycles per memory access, then step and compare.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input logic z, input int stall);
    int path[$];
    logic mrq[$];
    int k;
    logic [17:0] e;
    k = klass(op, fn);
    for (int i = 0; i < stall; i++) begin path.push_back(0); mrq.push_back(1'b0); end
    path.push_back(0); mrq.push_back(1'b1);
    path.push_back(1); mrq.push_back(1'($urandom));
    case (k)
      0: begin
        path.push_back(2); mrq.push_back(1'($urandom));
        for (int i = 0; i < stall; i++) begin path.push_back(3); mrq.push_back(1'b0); end
        path.push_back(3); mrq.push_back(1'b1);
        path.push_back(4); mrq.push_back(1'($urandom));
      end
      1: begin
        path.push_back(2); mrq.push_back(1'($urandom));
        for (int i = 0; i < stall; i++) begin path.push_back(5); mrq.push_back(1'b0); end
        path.push_back(5); mrq.push_back(1'b1);
      end
      2: begin path.push_back(6); mrq.push_back(1'($urandom));
               path.push_back(7); mrq.push_back(1'($urandom)); end
      3: begin path.push_back(10); mrq.push_back(1'($urandom));
               path.push_back(11); mrq.push_back(1'($urandom)); end
      4: begin path.push_back(8); mrq.push_back(1'($urandom)); end
      5: begin path.push_back(9); mrq.push_back(1'($urandom)); end
      default: ;
    endcase
    for (int i = 0; i < path.size(); i++) begin
      @(negedge clk);
      mem_ready = mrq[i];
      zero      = (path[i] == 8) ? z : 1'($urandom);
      opcode    = (path[i] == 0) ? 6'($urandom) : op;
      funct     = (path[i] == 0) ? 6'($urandom) : fn;
      #1;
      checks++;
      if (state !== 4'(path[i])) begin
        errors++;
        $display("FAIL %s state cyc%0d actual=%0d expected=%0d", name, i, state, path[i]);
      end
      e = exp_ctl(path[i], op, fn, zero, mem_ready);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s ctl cyc%0d st=%0d actual=%h expected=%h", name, i, path[i], act, e);
      end
      if (i == 0) begin
        checks++;
        if (retired !== exp_retired) begin
          errors++;
          $display("FAIL %s retired actual=%0d expected=%0d", name, retired, exp_retired);
        end
      end
    end
    exp_retired++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1; opcode = 6'h23; funct = 6'h20; zero = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || retired !== 32'd0) begin
      errors++;
      $display("FAIL reset_state actual=%0d/%0d expected=0/0", state, retired);
    end
    checks++;
    if (act[17:7] !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs actual=%h expected=000", act[17:7]);
    end
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || act !== exp_ctl(0, opcode, funct, zero, 1'b0)) begin
      errors++;
      $display("FAIL reset_release actual=%0d/%h expected=0/%h", state, act,
               exp_ctl(0, opcode, funct, zero, 1'b0));
    end
    exp_retired = 0;
  endtask

  task automatic test_lw();
    run_instr("lw", 6'h23, 6'h00, 1'b0, 0);
  endtask

  task automatic test_rtype();
    run_instr("add", 6'h00, 6'h20, 1'b0, 0);
    run_instr("sub", 6'h00, 6'h22, 1'b0, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (retired !== exp_retired) begin
      errors++;
      $display("FAIL rtype_retired actual=%0d expected=%0d", retired, exp_retired);
    end
  endtask

  task automatic test_branch();
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0);
    run_instr("bne_z1", 6'h05, 6'h00, 1'b1, 0);
    run_instr("bne_z0", 6'h05, 6'h00, 1'b0, 0);
    run_instr("jump", 6'h02, 6'h00, 1'b0, 0);
  endtask

  task automatic test_sw_stall();
    run_instr("sw_stall3", 6'h2B, 6'h00, 1'b0, 3);
    run_instr("lw_stall2", 6'h23, 6'h00, 1'b0, 2);
  endtask

  task automatic test_illegal();
    run_instr("illegal_3f", 6'h3F, 6'h00, 1'b0, 0);
    run_instr("illegal_funct", 6'h00, 6'h21, 1'b0, 1);
    run_instr("ori", 6'h0D, 6'h3F, 1'b0, 0);
    run_instr("andi", 6'h0C, 6'h00, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [5:0] rf[5];
    logic [5:0] ri[4];
    logic [5:0] op, fn;
    int c;
    rf = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    ri = '{6'h08, 6'h0C, 6'h0D, 6'h0A};
    for (int n = 0; n < 60; n++) begin
      c  = int'($urandom_range(0, 6));
      fn = 6'($urandom);
      case (c)
        0: op = 6'h23;
        1: op = 6'h2B;
        2: begin op = 6'h00; fn = rf[$urandom_range(0, 4)]; end
        3: op = ri[$urandom_range(0, 3)];
        4: op = $urandom_range(0, 1) ? 6'h04 : 6'h05;
        5: op = 6'h02;
        default: begin
          op = 6'($urandom);
          if (klass(op, fn) != 6) op = 6'h3F;
        end
      endcase
      run_instr("random", op, fn, 1'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

  // Zero-wait cycle count from first FETCH cycle until FETCH is re-entered
  task automatic test_latency();
    logic [5:0] ops[7];
    int lat[7];
    int n;
    ops = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02, 6'h3F};
    lat = '{5, 4, 4, 4, 3, 3, 2};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      mem_ready = 1'b1; opcode = ops[k]; funct = 6'h25;
      n = 1;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        #1;
        if (state === 4'd0) begin
          mem_ready = 1'b0;
          break;
        end
        n++;
      end
      checks++;
      if (n != lat[k]) begin
        errors++;
        $display("FAIL latency op=%h actual=%0d expected=%0d", ops[k], n, lat[k]);
      end
      exp_retired++;
    end
    checks++;
    if (retired !== exp_retired) begin
      errors++;
      $display("FAIL latency_retired actual=%0d expected=%0d", retired, exp_retired);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); mem_ready = 1'b1; opcode = 6'h23; funct = 6'h00;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'd3 || act[17:7] !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_memrd actual=%0d/%h expected=3/000", state, act[17:7]);
    end
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || retired !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_after actual=%0d/%0d expected=0/0", state, retired);
    end
  endtask

  initial begin
    rst = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_sw_stall();
    test_illegal();
    test_random();
    test_latency();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1: synchronous, active-low reset (sampled on rising clk edge while 0).
REQ-004 SHALL have ports opcode  input  6 and funct  input  6: IR[31:26] and IR[5:0].
REQ-005 SHALL have port zero  input  1: ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1: memory access completes in the cycle it is 1.
REQ-007 SHALL have 1-bit outputs PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ExtZero, illegal_op.
REQ-008 SHALL have outputs ALUSrcB 2, PCSource 2, ALUOp 3, state 4, retired CNT_W.

Function
REQ-009 SHALL be a Moore FSM plus mem_ready/zero qualification; outputs combinational from state register; any output not listed for a state is 0.
REQ-010 SHALL encode states: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, RTWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11; 12-15 unreachable, go to FETCH.
REQ-011 SHALL encode ALUOp: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-012 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00; IRWrite=PCWrite=mem_ready; stay while mem_ready=0, else DECODE.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=add; next: 0x23/0x2B->MEMADR, 0x00 with legal funct->RTEXEC, 0x04/0x05->BRANCH, 0x02->JUMP, 0x08/0x0C/0x0D/0x0A->IEXEC, else FETCH with illegal_op=1 for that cycle.
REQ-014 Legal R-type funct SHALL be 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt; other funct is illegal per REQ-013.
REQ-015 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=add; next MEMRD for 0x23, MEMWR for 0x2B.
REQ-016 MEMRD SHALL drive MemRead=1, IorD=1; stay while mem_ready=0, else MEMWB.
REQ-017 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=1 (write rt); next FETCH.
REQ-018 MEMWR SHALL drive MemWrite=1, IorD=1; stay while mem_ready=0, else FETCH.
REQ-019 RTEXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp from funct per REQ-014; next RTWB.
REQ-020 RTWB SHALL drive RegWrite=1, MemtoReg=0, RegDst=0 (write rd), ALUOp held as RTEXEC; next FETCH.
REQ-021 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSource=01, PCWrite=zero for 0x04, ~zero for 0x05; next FETCH.
REQ-022 JUMP SHALL drive PCSource=10, PCWrite=1; next FETCH.
REQ-023 IEXEC SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp add/and/or/slt for 0x08/0x0C/0x0D/0x0A, ExtZero=1 only for 0x0C/0x0D; next IWB.
REQ-024 IWB SHALL drive RegWrite=1, MemtoReg=0, RegDst=1, ALUOp/ExtZero held as IEXEC; next FETCH.
REQ-025 Zero-wait latency SHALL be: lw 5, sw 4, R-type 4, I-type 4, branch 3, jump 3, illegal 2 cycles.
REQ-026 retired SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, RTWB, BRANCH, JUMP, IWB or illegal DECODE; wraps modulo 2^CNT_W.
REQ-027 state output SHALL equal the state register.
REQ-028 mem_ready SHALL be ignored in states without a memory access.

Reset
REQ-029 While rst=0, all 1-bit outputs and PCWrite/RegWrite/MemWrite/IRWrite SHALL be forced 0 in that same cycle.
REQ-030 On clk edge with rst=0: state<=FETCH, retired<=0; reset mid-instruction aborts without any further write.
REQ-031 After rst returns to 1, first fetch SHALL begin in the next cycle.

Verification
REQ-032 lw (0x23), mem_ready=1 always -> states 0,1,2,3,4,0; RegWrite=1,MemtoReg=1,RegDst=1 only in state 4; retired 0->1.
REQ-033 add (op 0, funct 0x20) then sub 0x22 -> ALUOp 000 then 001 in states 6/7; RegDst=0; retired=2 after 8 cycles.
REQ-034 beq with zero=1 -> PCWrite=1, PCSource=01 in state 8; bne with zero=1 -> PCWrite=0.
REQ-035 sw with mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, state 5 held, then FETCH.
REQ-036 opcode 0x3F -> illegal_op=1 one cycle in DECODE, no RegWrite/MemWrite, next FETCH, retired+1.
REQ-037 rst=0 asserted in MEMRD -> RegWrite/MemRead=0 that cycle, next state 0, retired=0.
